mem_arbiter: RTL
================

# mem_arbiter

- Sits directly downstream of the cache block (icache + dcache).
- Arbitrates the instruction-fetch and data read/write requests those caches issue, and serialises them onto the single-ported RAM interface.
- Drives the per-client wait/load responses back to the caches.
- Registered request launch, fixed data-first priority with alternation under contention, and a timeout watchdog.

## Interface
Parameters:
- TIMEOUT, 255: max cycles a launched access may wait for ramstate==ACCESS before abort (8-bit counter).
- ERRWORD, 32'hBAD1BAD1: load value returned on an aborted or errored access.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  synchronous, active-high reset (1 = reset, sampled on CLK rising edge).
- iREN  in  1  instruction read request from icache.
- iaddr  in  32  instruction address.
- dREN  in  1  data read request from dcache.
- dWEN  in  1  data write request from dcache; dREN&dWEN together is treated as a write.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- iwait  out  1  0 only in the completion cycle of an instruction access.
- dwait  out  1  0 only in the completion cycle of a data access.
- iload  out  32  instruction word, valid when iwait==0.
- dload  out  32  data word, valid when dwait==0 on a read.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write value.
- ramload  in  32  RAM read value.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- err  out  1  sticky; set on ERROR or timeout, cleared only by reset.

## Operation
- States:
  - IDLE: no RAM strobes.
  - DACC: data access in flight.
  - IACC: instruction access in flight.
- Latched registers: addr, store, op (read/write), client, 8-bit timer, last-served client (lastd).
- Arbitration in IDLE:
  - Data pending (dREN|dWEN) only -> DACC; latch daddr, dstore, op=dWEN.
  - iREN only -> IACC; latch iaddr.
  - Both pending -> IACC if lastd==1, else DACC.
  - lastd resets to 0, so data wins the first tie.
  - Neither pending -> stay in IDLE.
- In DACC/IACC:
  - ramREN/ramWEN are driven from the latched op; ramaddr/ramstore from the latched registers.
  - Address/data changes on the client inputs are ignored.
- Completion (ramstate==ACCESS):
  - Owning client's wait=0 that cycle; its load=ramload.
  - lastd <= (state==DACC); next state IDLE.
- ramstate==ERROR:
  - Owning wait=0, load=ERRWORD, err<=1, next state IDLE.
- Timeout: timer resets to 0 on launch and increments each cycle in DACC/IACC. When timer==TIMEOUT and ramstate!=ACCESS:
  - Owning wait=0, load=ERRWORD, err<=1, next state IDLE.
- Withdrawal: owning request deasserts before completion -> next state IDLE, no wait pulse. RAM strobes drop the following cycle.
- Non-owning client:
  - Wait held at 1; load=0.
  - Its request stays pending and is arbitrated at the next IDLE.
- Reset (asserted at any time, including mid-access):
  - Next cycle: state IDLE, lastd=0, err=0, timer=0.
  - All outputs at reset values: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, err=0.

## Timing
- Launch latency: request asserted in IDLE at cycle 0 -> strobes/address on RAM at cycle 1.
- Completion: combinational from ramstate in the same cycle; earliest is cycle 1 (zero-wait RAM).
- Turnaround:
  - Cycle after completion is always IDLE (no strobes).
  - A request still asserted there launches at the next cycle.
  - Back-to-back accesses to a zero-wait RAM therefore complete every 2 cycles.
- Outputs:
  - wait/load are combinational in state and ramstate.
  - RAM-side outputs are purely registered-state driven (no input-to-RAM combinational path).
- Timer saturates conceptually at TIMEOUT; abort occurs exactly TIMEOUT cycles after launch.

## Test plan
- Reset mid-access: nRST=1 during DACC with ramstate=BUSY -> next cycle ramWEN=0, dwait=1, err=0, state IDLE.
- Single fetch: iREN=1, iaddr=0x40; ramstate=ACCESS in cycle 3 with ramload=0x8C220004 -> ramREN=1, ramaddr=0x40 in cycles 1-3; iwait=0, iload=0x8C220004 in cycle 3 only.
- Contention: iREN=dWEN=1 held, daddr=0x100, dstore=0xDEADBEEF, RAM zero-wait -> write completes in cycle 1 (dwait=0); fetch launches cycle 3 and completes in cycle 3 (iwait=0); then data again at cycle 5.
- Withdrawal: dREN=1 at cycle 0, dropped at cycle 2 with ramstate=BUSY -> no dwait pulse; ramREN=0 at cycle 3; pending iREN launches at cycle 4.
- Error: ramstate=ERROR during IACC -> iwait=0, iload=0xBAD1BAD1, err=1 and stays 1 through later good accesses.
- Timeout with TIMEOUT=4: ramstate held BUSY -> dwait=0, dload=0xBAD1BAD1 at launch+4; err=1; IDLE next cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side bus of the memory arbiter.
// slave is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, dwait, iload, dload,
        output ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, dwait, iload, dload,
        input  ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises icache fetches and dcache accesses onto one RAM port,
// data-first with alternation on ties, plus a timeout watchdog.
module mem_arbiter #(
    parameter logic [7:0]  TIMEOUT = 8'd255,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_store;
    logic        r_wr;
    logic        r_lastd;
    logic        r_err;
    logic [7:0]  r_timer;

    logic        w_dpend;
    logic        w_req;
    logic        w_done;
    logic        w_abort;
    logic        w_fin;
    logic        w_launch_d;
    logic        w_launch_i;
    logic [31:0] w_resp;

    assign w_dpend = bus.dREN | bus.dWEN;

    always_comb begin
        w_next     = r_state;
        w_done     = 1'b0;
        w_abort    = 1'b0;
        w_launch_d = 1'b0;
        w_launch_i = 1'b0;
        w_req      = (r_state == IACC) ? bus.iREN : w_dpend;
        case (r_state)
            IDLE: begin
                if (w_dpend && (!bus.iREN || !r_lastd)) begin
                    w_launch_d = 1'b1;
                    w_next     = DACC;
                end else if (bus.iREN) begin
                    w_launch_i = 1'b1;
                    w_next     = IACC;
                end
            end
            DACC, IACC: begin
                // A withdrawn request ends the access silently.
                if (!w_req) begin
                    w_next = IDLE;
                end else if (bus.ramstate == RS_ACCESS) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else if (bus.ramstate == RS_ERROR ||
                             r_timer == TIMEOUT) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_fin  = w_done | w_abort;
    assign w_resp = w_done ? bus.ramload : ERRWORD;

    always_comb begin
        bus.iwait = !(w_fin && r_state == IACC);
        bus.dwait = !(w_fin && r_state == DACC);
        bus.iload = (w_fin && r_state == IACC) ? w_resp : '0;
        bus.dload = (w_fin && r_state == DACC) ? w_resp : '0;
    end

    // RAM side depends on registered state only.
    always_comb begin
        bus.ramREN   = (r_state == IACC) || (r_state == DACC && !r_wr);
        bus.ramWEN   = (r_state == DACC) && r_wr;
        bus.ramaddr  = (r_state == IDLE) ? '0 : r_addr;
        bus.ramstore = (r_state == DACC) ? r_store : '0;
        bus.err      = r_err;
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_store <= '0;
            r_wr    <= 1'b0;
            r_lastd <= 1'b0;
            r_err   <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            if (w_launch_d) begin
                r_addr  <= bus.daddr;
                r_store <= bus.dstore;
                r_wr    <= bus.dWEN;
                r_timer <= '0;
            end else if (w_launch_i) begin
                r_addr  <= bus.iaddr;
                r_store <= '0;
                r_wr    <= 1'b0;
                r_timer <= '0;
            end else if (r_state != IDLE) begin
                r_timer <= r_timer + 8'd1;
            end
            if (w_done) begin
                r_lastd <= (r_state == DACC);
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule
